// File: rtl/battle_menu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : battle_menu_pkg
//  Description : Shared types and constants for the player-turn battle menu:
//                command actions, controller states and grid cell indices.
//  Revision    : 1.0  initial release
// ============================================================================
package battle_menu_pkg;

    // Command handed to the battle engine; encoding matches the main grid cell.
    typedef enum logic [1:0] {
        FIGHT  = 2'd0,
        BAG    = 2'd1,
        SWITCH = 2'd2,
        RUN    = 2'd3
    } action_e;

    // Controller states with an explicit 3-bit encoding.
    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_MAIN  = 3'd1,
        S_MOVE  = 3'd2,
        S_ISSUE = 3'd3,
        S_LOCK  = 3'd4
    } state_e;

    // 2x2 grid cell index: bit1 = row, bit0 = col.
    typedef logic [1:0] grid_idx_t;

    localparam grid_idx_t CUR_FIGHT = 2'd0;
    localparam int        ROW_BIT   = 1;
    localparam int        COL_BIT   = 0;

endpackage : battle_menu_pkg
`default_nettype wire

// File: rtl/menu_grid_cursor.sv
`default_nettype none
// ============================================================================
//  Module      : menu_grid_cursor
//  Description : 2x2 saturating cursor register. Up/down select the row,
//                left/right select the column; opposing presses in the same
//                axis cancel. Clear has priority over enable. A single
//                instance serves both the main grid and the move grid.
//  Revision    : 1.0  initial release
// ============================================================================
module menu_grid_cursor
    import battle_menu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       clr,
    input  logic       en,
    output logic [1:0] cursor
);

    grid_idx_t r_cursor;

    // Cursor register: clear wins, otherwise apply unopposed directions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cursor <= CUR_FIGHT;
        end else if (clr) begin
            r_cursor <= CUR_FIGHT;
        end else if (en) begin
            if (up && !down) begin
                r_cursor[ROW_BIT] <= 1'b0;
            end else if (down && !up) begin
                r_cursor[ROW_BIT] <= 1'b1;
            end
            if (left && !right) begin
                r_cursor[COL_BIT] <= 1'b0;
            end else if (right && !left) begin
                r_cursor[COL_BIT] <= 1'b1;
            end
        end
    end

    assign cursor = r_cursor;

endmodule : menu_grid_cursor
`default_nettype wire

// File: rtl/battle_menu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : battle_menu_ctrl
//  Description : Player-turn battle menu controller. Navigates the 2x2 main
//                grid (FIGHT/BAG/SWITCH/RUN) and the 2x2 move grid from
//                one-cycle button pulses, hands one command per turn to the
//                battle engine over valid/ready, then ignores input for
//                LOCKOUT cycles before waiting for the next turn.
//  Revision    : 1.0  initial release
// ============================================================================
module battle_menu_ctrl
    import battle_menu_pkg::*;
#(
    parameter int LOCKOUT = 16,
    parameter int LOCK_W  = $clog2(LOCKOUT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       up_p,
    input  logic       down_p,
    input  logic       left_p,
    input  logic       right_p,
    input  logic       a_p,
    input  logic       b_p,
    input  logic       menu_en,
    input  logic [3:0] move_ok,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_action,
    output logic [1:0] cmd_move,
    output logic       cmd_struggle,
    output logic [1:0] cursor,
    output logic       in_move_menu
);

    // A zero lockout still needs a one-bit counter to keep the RTL legal.
    localparam int                c_cnt_w     = (LOCK_W > 0) ? LOCK_W : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_one  = 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(LOCKOUT);

    state_e              r_state;
    logic                r_cmd_valid;
    action_e             r_cmd_action;
    grid_idx_t           r_cmd_move;
    logic                r_cmd_struggle;
    logic                r_in_move_menu;
    logic [c_cnt_w-1:0]  r_lock_cnt;

    grid_idx_t           w_cursor;
    logic                w_cur_clr;
    logic                w_cur_en;
    logic                w_sel_ok;
    logic                w_all_dead;

    assign w_sel_ok   = move_ok[w_cursor];
    assign w_all_dead = (move_ok == 4'b0000);

    // Cursor control: clear on menu entry/exit and grid changes; move only
    // when no A/B press is present in a navigable state.
    always_comb begin
        w_cur_clr = 1'b0;
        w_cur_en  = 1'b0;
        case (r_state)
            S_WAIT: begin
                w_cur_clr = menu_en;
            end
            S_MAIN: begin
                if (!menu_en) begin
                    w_cur_clr = 1'b1;
                end else if (b_p) begin
                    w_cur_clr = 1'b0;
                end else if (a_p) begin
                    w_cur_clr = (w_cursor == CUR_FIGHT);
                end else begin
                    w_cur_en = 1'b1;
                end
            end
            S_MOVE: begin
                if (!menu_en || b_p) begin
                    w_cur_clr = 1'b1;
                end else if (!a_p) begin
                    w_cur_en = 1'b1;
                end
            end
            default: begin
                w_cur_clr = 1'b0;
                w_cur_en  = 1'b0;
            end
        endcase
    end

    menu_grid_cursor u_cursor (
        .clk    (clk),
        .rst_n  (rst_n),
        .up     (up_p),
        .down   (down_p),
        .left   (left_p),
        .right  (right_p),
        .clr    (w_cur_clr),
        .en     (w_cur_en),
        .cursor (w_cursor)
    );

    // Menu state machine with registered command and menu outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_WAIT;
            r_cmd_valid    <= 1'b0;
            r_cmd_action   <= FIGHT;
            r_cmd_move     <= 2'd0;
            r_cmd_struggle <= 1'b0;
            r_in_move_menu <= 1'b0;
            r_lock_cnt     <= '0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    // A new turn always opens on the main grid.
                    if (menu_en) begin
                        r_state        <= S_MAIN;
                        r_in_move_menu <= 1'b0;
                    end
                end
                S_MAIN: begin
                    if (!menu_en) begin
                        r_state        <= S_WAIT;
                        r_in_move_menu <= 1'b0;
                    end else if (!b_p && a_p) begin
                        if (w_cursor == CUR_FIGHT) begin
                            r_state        <= S_MOVE;
                            r_in_move_menu <= 1'b1;
                        end else begin
                            r_state        <= S_ISSUE;
                            r_cmd_valid    <= 1'b1;
                            r_cmd_action   <= action_e'(w_cursor);
                            r_cmd_move     <= 2'd0;
                            r_cmd_struggle <= 1'b0;
                        end
                    end
                end
                S_MOVE: begin
                    if (!menu_en) begin
                        r_state        <= S_WAIT;
                        r_in_move_menu <= 1'b0;
                    end else if (b_p) begin
                        r_state        <= S_MAIN;
                        r_in_move_menu <= 1'b0;
                    end else if (a_p) begin
                        // A dead move is ignored unless every move is dead,
                        // in which case the engine is told to struggle.
                        if (w_sel_ok) begin
                            r_state        <= S_ISSUE;
                            r_cmd_valid    <= 1'b1;
                            r_cmd_action   <= FIGHT;
                            r_cmd_move     <= w_cursor;
                            r_cmd_struggle <= 1'b0;
                        end else if (w_all_dead) begin
                            r_state        <= S_ISSUE;
                            r_cmd_valid    <= 1'b1;
                            r_cmd_action   <= FIGHT;
                            r_cmd_move     <= 2'd0;
                            r_cmd_struggle <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    // Command fields stay put; they remain readable afterwards.
                    if (r_cmd_valid && cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        if (LOCKOUT == 0) begin
                            r_state <= S_WAIT;
                        end else begin
                            r_state    <= S_LOCK;
                            r_lock_cnt <= c_cnt_load;
                        end
                    end
                end
                S_LOCK: begin
                    // Leaving at count 1 yields exactly LOCKOUT cycles here.
                    if (r_lock_cnt <= c_cnt_one) begin
                        r_state    <= S_WAIT;
                        r_lock_cnt <= '0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt - c_cnt_one;
                    end
                end
                default: begin
                    r_state <= S_WAIT;
                end
            endcase
        end
    end

    assign cmd_valid    = r_cmd_valid;
    assign cmd_action   = r_cmd_action;
    assign cmd_move     = r_cmd_move;
    assign cmd_struggle = r_cmd_struggle;
    assign cursor       = w_cursor;
    assign in_move_menu = r_in_move_menu;

endmodule : battle_menu_ctrl
`default_nettype wire

// File: tb/tb_battle_menu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_battle_menu_ctrl
//  Description : Self-checking bench for battle_menu_ctrl: directed vector
//                table, hand-written handshake/reset sequences and random
//                stimulus against a behavioural menu model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_battle_menu_ctrl;

    localparam logic [5:0] P_U = 6'd1;
    localparam logic [5:0] P_D = 6'd2;
    localparam logic [5:0] P_L = 6'd4;
    localparam logic [5:0] P_R = 6'd8;
    localparam logic [5:0] P_A = 6'd16;
    localparam logic [5:0] P_B = 6'd32;
    localparam int         LOCK_CYC = 16;

    // Model modes (bench-local, not the DUT encoding).
    localparam int M_WAIT = 0, M_MAIN = 1, M_MOVES = 2, M_ISSUE = 3, M_LOCK = 4;

    typedef struct packed {
        logic [5:0] btn;   // {b, a, right, left, down, up}
        logic       men;
        logic [3:0] ok;
        logic       rdy;
    } in_t;

    typedef struct {
        in_t        i;
        logic [8:0] exp;   // {valid, action, move, struggle, cursor, in_move}
        string      name;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       up_p, down_p, left_p, right_p, a_p, b_p;
    logic       menu_en;
    logic [3:0] move_ok;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [1:0] cmd_action;
    logic [1:0] cmd_move;
    logic       cmd_struggle;
    logic [1:0] cursor;
    logic       in_move_menu;
    logic [8:0] dut_o;

    int n_vec;
    int n_fail;
    int hs_cnt;

    vec_t tbl[$];

    // Behavioural model state.
    int m_mode, m_row, m_col, m_lock, m_act, m_mv;
    bit m_valid, m_st, m_mm;

    battle_menu_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .up_p         (up_p),
        .down_p       (down_p),
        .left_p       (left_p),
        .right_p      (right_p),
        .a_p          (a_p),
        .b_p          (b_p),
        .menu_en      (menu_en),
        .move_ok      (move_ok),
        .cmd_ready    (cmd_ready),
        .cmd_valid    (cmd_valid),
        .cmd_action   (cmd_action),
        .cmd_move     (cmd_move),
        .cmd_struggle (cmd_struggle),
        .cursor       (cursor),
        .in_move_menu (in_move_menu)
    );

    assign dut_o = {cmd_valid, cmd_action, cmd_move, cmd_struggle, cursor, in_move_menu};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] o(bit v, int act, int mv, bit st, int cur, bit mm);
        return {v, 2'(act), 2'(mv), st, 2'(cur), mm};
    endfunction

    function automatic in_t mk(logic [5:0] btn, bit men, logic [3:0] ok, bit rdy);
        in_t r;
        r.btn = btn;
        r.men = men;
        r.ok  = ok;
        r.rdy = rdy;
        return r;
    endfunction

    function automatic void add(logic [5:0] btn, bit men, logic [3:0] ok, bit rdy,
                                logic [8:0] e, string nm);
        vec_t r;
        r.i    = mk(btn, men, ok, rdy);
        r.exp  = e;
        r.name = nm;
        tbl.push_back(r);
    endfunction

    function automatic void model_reset();
        m_mode = M_WAIT; m_row = 0; m_col = 0; m_lock = 0;
        m_act = 0; m_mv = 0; m_valid = 0; m_st = 0; m_mm = 0;
    endfunction

    function automatic void model_issue(int act, int mv, bit st);
        m_mode = M_ISSUE; m_valid = 1; m_act = act; m_mv = mv; m_st = st;
    endfunction

    // One clock of the menu rules applied to the inputs seen at that edge.
    function automatic void model_step(in_t v);
        bit pu, pd, pl, pr, pa, pb;
        int cur;
        {pb, pa, pr, pl, pd, pu} = v.btn;
        cur = 2 * m_row + m_col;
        case (m_mode)
            M_WAIT: if (v.men) begin m_mode = M_MAIN; m_row = 0; m_col = 0; m_mm = 0; end
            M_MAIN, M_MOVES: begin
                if (!v.men) begin
                    m_mode = M_WAIT; m_row = 0; m_col = 0; m_mm = 0;
                end else if (pb) begin
                    if (m_mode == M_MOVES) begin m_mode = M_MAIN; m_row = 0; m_col = 0; m_mm = 0; end
                end else if (pa) begin
                    if (m_mode == M_MAIN) begin
                        if (cur == 0) begin m_mode = M_MOVES; m_mm = 1; end
                        else model_issue(cur, 0, 0);
                    end else if (v.ok[cur]) begin
                        model_issue(0, cur, 0);
                    end else if (v.ok == 4'b0000) begin
                        model_issue(0, 0, 1);
                    end
                end else begin
                    if (pu && !pd) m_row = 0;
                    if (pd && !pu) m_row = 1;
                    if (pl && !pr) m_col = 0;
                    if (pr && !pl) m_col = 1;
                end
            end
            M_ISSUE: if (v.rdy) begin m_valid = 0; m_mode = M_LOCK; m_lock = LOCK_CYC; end
            default: begin
                m_lock = m_lock - 1;
                if (m_lock == 0) m_mode = M_WAIT;
            end
        endcase
    endfunction

    function automatic logic [8:0] model_out();
        return o(m_valid, m_act, m_mv, m_st, 2 * m_row + m_col, m_mm);
    endfunction

    function automatic void check(string nm, logic [8:0] exp);
        n_vec++;
        if (dut_o !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %h expected %h {valid,act,move,strug,cursor,inmove}",
                     nm, $time, dut_o, exp);
        end
    endfunction

    task automatic step(input in_t v);
        {b_p, a_p, right_p, left_p, down_p, up_p} = v.btn;
        menu_en   = v.men;
        move_ok   = v.ok;
        cmd_ready = v.rdy;
        if (cmd_valid && v.rdy) hs_cnt++;
        @(posedge clk);
        model_step(v);
        #1;
    endtask

    task automatic step_m(input in_t v, input string nm);
        step(v);
        check(nm, model_out());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {b_p, a_p, right_p, left_p, down_p, up_p} = '0;
        menu_en = 0; move_ok = '0; cmd_ready = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic in_t rnd_in(bit allow_rdy);
        in_t v;
        for (int b = 0; b < 6; b++) v.btn[b] = ($urandom_range(0, 3) == 0);
        v.men = ($urandom_range(0, 9) != 0);
        v.ok  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        v.rdy = allow_rdy && ($urandom_range(0, 1) == 1);
        return v;
    endfunction

    initial begin
        n_vec = 0; n_fail = 0; hs_cnt = 0;
        model_reset();

        // Directed table: RUN issue + lockout, move pick, struggle, A+B, chords.
        add(0,    1, 4'h0, 0, o(0,0,0,0,0,0), "wait_to_main");
        add(P_R,  1, 4'h0, 0, o(0,0,0,0,1,0), "right");
        add(P_D,  1, 4'h0, 0, o(0,0,0,0,3,0), "down");
        add(P_A,  1, 4'h0, 0, o(1,3,0,0,3,0), "issue_run");
        add(P_U|P_L, 0, 4'h0, 0, o(1,3,0,0,3,0), "issue_hold");
        add(0,    1, 4'h0, 1, o(0,3,0,0,3,0), "handshake_run");
        for (int k = 0; k < LOCK_CYC; k++) add(P_U|P_L, 1, 4'h0, 0, o(0,3,0,0,3,0), "lockout_run");
        add(P_A,  1, 4'h0, 0, o(0,3,0,0,0,0), "unlock_main");
        add(P_A,  1, 4'hB, 0, o(0,3,0,0,0,1), "enter_moves");
        add(P_D,  1, 4'hB, 0, o(0,3,0,0,2,1), "move_down");
        add(P_A,  1, 4'hB, 0, o(0,3,0,0,2,1), "dead_move_ignored");
        add(P_R,  1, 4'hB, 0, o(0,3,0,0,3,1), "move_right");
        add(P_A,  1, 4'hB, 0, o(1,0,3,0,3,1), "issue_move3");
        add(0,    1, 4'hB, 1, o(0,0,3,0,3,1), "handshake_move");
        for (int k = 0; k < LOCK_CYC; k++) add(P_A|P_R, 1, 4'h0, 0, o(0,0,3,0,3,1), "lockout_move");
        add(0,    1, 4'h0, 0, o(0,0,3,0,0,0), "unlock_main2");
        add(P_A,  1, 4'h0, 0, o(0,0,3,0,0,1), "enter_moves2");
        add(P_D|P_R, 1, 4'h0, 0, o(0,0,3,0,3,1), "diag_both_apply");
        add(P_A,  1, 4'h0, 0, o(1,0,0,1,3,1), "struggle");
        add(0,    1, 4'h0, 1, o(0,0,0,1,3,1), "handshake_struggle");
        for (int k = 0; k < LOCK_CYC; k++) add(0, 1, 4'h0, 0, o(0,0,0,1,3,1), "lockout_struggle");
        add(0,    1, 4'h0, 0, o(0,0,0,1,0,0), "unlock_main3");
        add(P_A,  1, 4'hF, 0, o(0,0,0,1,0,1), "enter_moves3");
        add(P_D,  1, 4'hF, 0, o(0,0,0,1,2,1), "move_down3");
        add(P_A|P_B, 1, 4'hF, 0, o(0,0,0,1,0,0), "a_and_b_back");
        add(P_D,  1, 4'h0, 0, o(0,0,0,1,2,0), "main_down");
        add(P_U|P_D, 1, 4'h0, 0, o(0,0,0,1,2,0), "up_down_cancel");
        add(P_L|P_R, 1, 4'h0, 0, o(0,0,0,1,2,0), "left_right_cancel");
        add(P_U|P_R, 1, 4'h0, 0, o(0,0,0,1,1,0), "up_right");
        add(P_B|P_D, 1, 4'h0, 0, o(0,0,0,1,1,0), "b_main_ignored");
        add(0,    0, 4'h0, 0, o(0,0,0,1,0,0), "menu_drop");
        add(P_R,  0, 4'h0, 0, o(0,0,0,1,0,0), "wait_ignores");

        rst_n = 1'b0;
        {b_p, a_p, right_p, left_p, down_p, up_p} = '0;
        menu_en = 0; move_ok = '0; cmd_ready = 0;
        #2;
        check("in_reset", 9'h000);
        do_reset();
        check("reset_state", 9'h000);

        foreach (tbl[n]) begin
            step(tbl[n].i);
            check(tbl[n].name, tbl[n].exp);
        end

        // Stalled command: presses and menu_en churn, then one transfer.
        step_m(mk(0,   1, 4'h0, 0), "stall_main");
        step_m(mk(P_R, 1, 4'h0, 0), "stall_right");
        step_m(mk(P_A, 1, 4'h0, 0), "stall_issue_bag");
        for (int k = 0; k < 10; k++) step_m(rnd_in(1'b0), "stall_hold");
        hs_cnt = 0;
        step_m(mk(0, 1, 4'h0, 1), "stall_accept");
        for (int k = 0; k < 6; k++) step_m(mk(P_A, 1, 4'h0, 1), "stall_after");
        n_vec++;
        if (hs_cnt != 1) begin
            n_fail++;
            $display("FAIL one_transfer: got %0d transfers expected 1", hs_cnt);
        end
        for (int k = 0; k < 20; k++) step_m(mk(0, 1, 4'h0, 0), "stall_drain");

        // Random stimulus against the model.
        for (int k = 0; k < 1500; k++) step_m(rnd_in(1'b1), "random");

        // Asynchronous reset between edges while a command is offered.
        do_reset();
        step_m(mk(0,       1, 4'h0, 0), "ar_main");
        step_m(mk(P_R|P_D, 1, 4'h0, 0), "ar_cursor3");
        step_m(mk(P_A,     1, 4'h0, 0), "ar_issue");
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_now", 9'h000);
        @(posedge clk);
        #1;
        check("async_reset_held", 9'h000);
        rst_n = 1'b1;
        model_reset();

        // Presses during lockout leave no trace once unlocked.
        step_m(mk(0,   1, 4'h0, 0), "lk_main");
        step_m(mk(P_A, 1, 4'h1, 0), "lk_moves");
        step_m(mk(P_A, 1, 4'h1, 0), "lk_issue");
        step_m(mk(0,   1, 4'h1, 1), "lk_accept");
        for (int k = 0; k < LOCK_CYC; k++) step_m(mk(6'($urandom_range(0, 63)), 1, 4'h1, 0), "lk_presses");
        step_m(mk(0,   1, 4'h0, 0), "lk_unlock");
        step_m(mk(0,   1, 4'h0, 0), "lk_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_battle_menu_ctrl
`default_nettype wire
